rr_arbiter_weighted: RTL

Parametrised weighted round-robin arbiter. It is the successor to the plain rotating queue selector and sits between the per-queue FIFOs and the shared output path. Each queue gets a configurable burst of transfers per turn. Queues that are empty can optionally be skipped. Transfers use a ready/valid handshake with the downstream consumer and produce a one-hot pop back to the FIFOs.

---
 rtl/rr_arbiter_weighted_if.sv | 36 +++
 rtl/rr_arbiter_weighted.sv | 97 +++++++++
 2 files changed

// File: rtl/rr_arbiter_weighted_if.sv
// Handshake/bus bundle between the per-queue FIFOs, the weighted round-robin
// arbiter and the downstream consumer.
//   enb        : global enable (0 freezes the arbiter, outputs idle)
//   buf_empty  : per-queue FIFO empty flags, bit i = queue i
//   weights    : burst length per queue, queue i at [i*WEIGHT_BITS +: WEIGHT_BITS]
//   out_ready  : downstream accepts a datum this cycle
//   selector   : registered index of the granted queue (data mux select)
//   out_enb    : combinational valid toward the consumer
//   pop        : combinational one-hot read strobe back to the FIFOs
//   burst_last : combinational, final transfer of the current turn
// master = arbiter side, slave = FIFO/consumer side.
interface rr_arbiter_weighted_if #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned WEIGHT_BITS    = 3
);
  localparam int unsigned SEL_W = $clog2(QUEUE_QUANTITY);

  logic                                  enb;
  logic [QUEUE_QUANTITY-1:0]             buf_empty;
  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights;
  logic                                  out_ready;
  logic [SEL_W-1:0]                      selector;
  logic                                  out_enb;
  logic [QUEUE_QUANTITY-1:0]             pop;
  logic                                  burst_last;

  modport master (
    input  enb, buf_empty, weights, out_ready,
    output selector, out_enb, pop, burst_last
  );

  modport slave (
    output enb, buf_empty, weights, out_ready,
    input  selector, out_enb, pop, burst_last
  );
endinterface

// File: rtl/rr_arbiter_weighted.sv
// Weighted round-robin arbiter between per-queue FIFOs and a shared output path.
// Each queue gets a burst of eff_w(i) transfers per turn (weight 0 counts as 1).
// Ports:
//   clk : single clock, all state updates on posedge
//   rst : synchronous active-low reset
//   bus : rr_arbiter_weighted_if.master (enb, buf_empty, weights, out_ready in;
//         selector, out_enb, pop, burst_last out)
module rr_arbiter_weighted #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned WEIGHT_BITS    = 3,
  parameter int unsigned SKIP_EMPTY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_arbiter_weighted_if.master bus
);

  localparam int unsigned SEL_W  = $clog2(QUEUE_QUANTITY);
  localparam int unsigned W_BUS  = QUEUE_QUANTITY * WEIGHT_BITS;
  localparam int unsigned LAST_Q = QUEUE_QUANTITY - 1;

  logic [SEL_W-1:0]          sel_q, sel_d, nxt_sel;
  logic [WEIGHT_BITS-1:0]    credit_q, credit_d;
  logic                      out_enb_c;
  logic [QUEUE_QUANTITY-1:0] pop_c;
  logic                      burst_last_c;

  // Burst length of queue idx; a zero weight still grants one transfer.
  function automatic logic [WEIGHT_BITS-1:0] eff_w(
    input logic [W_BUS-1:0] w,
    input logic [SEL_W-1:0] idx
  );
    logic [WEIGHT_BITS-1:0] v;
    v = w[idx*WEIGHT_BITS +: WEIGHT_BITS];
    return (v == '0) ? WEIGHT_BITS'(1) : v;
  endfunction

  // Cyclic increment that never leaves [0, QUEUE_QUANTITY-1] for non-power-of-two counts.
  function automatic logic [SEL_W-1:0] inc_idx(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(LAST_Q)) ? '0 : idx + SEL_W'(1);
  endfunction

  // Next grant: plain rotation, or first non-empty queue after the current one
  // (the current queue itself is the last candidate, so a sole busy queue is re-granted).
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] cand;
    nxt_sel = inc_idx(sel_q);
    found   = 1'b0;
    cand    = sel_q;
    if (SKIP_EMPTY != 0) begin
      for (int k = 0; k < int'(QUEUE_QUANTITY); k++) begin
        cand = inc_idx(cand);
        if (!found && !bus.buf_empty[cand]) begin
          nxt_sel = cand;
          found   = 1'b1;
        end
      end
    end
  end

  // Handshake outputs and HOLD / XFER / ADVANCE next-state selection.
  always_comb begin
    out_enb_c     = bus.enb & rst & ~bus.buf_empty[sel_q];
    pop_c         = '0;
    pop_c[sel_q]  = out_enb_c & bus.out_ready;
    burst_last_c  = out_enb_c & (credit_q == WEIGHT_BITS'(1));
    sel_d         = sel_q;
    credit_d      = credit_q;
    if (bus.enb && !(out_enb_c && !bus.out_ready)) begin
      if (out_enb_c && (credit_q > WEIGHT_BITS'(1))) begin
        credit_d = credit_q - WEIGHT_BITS'(1);
      end else begin
        // Burst end or empty grant: move on and load fresh credit from current weights.
        sel_d    = nxt_sel;
        credit_d = eff_w(bus.weights, nxt_sel);
      end
    end
  end

  // Grant and credit registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q    <= '0;
      credit_q <= eff_w(bus.weights, SEL_W'(0));
    end else begin
      sel_q    <= sel_d;
      credit_q <= credit_d;
    end
  end

  assign bus.selector   = sel_q;
  assign bus.out_enb    = out_enb_c;
  assign bus.pop        = pop_c;
  assign bus.burst_last = burst_last_c;

endmodule
